// File: rtl/fb_painter.sv
// Framebuffer painter: stamps a clamped square brush or clears the whole screen, one pixel write per cycle.
// Latency: request sampled in IDLE, one SETUP cycle, first write presented two cycles after the request edge.
// Backpressure: wr_en/wr_addr/wr_data hold while wr_ready=0; the raster advances only on an accepted write.
module fb_painter #(
  parameter int         RESOLUTION_H = 640,
  parameter int         RESOLUTION_V = 480,
  parameter int         HPOS_WIDTH   = 10,
  parameter int         VPOS_WIDTH   = 10,
  parameter int         ADDR_WIDTH   = 19,
  parameter int         BRUSH_SIZE   = 20,
  parameter logic [2:0] CLEAR_COLOR  = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  paint_req,
  input  logic                  clear_req,
  input  logic [HPOS_WIDTH-1:0] cursor_xpos,
  input  logic [VPOS_WIDTH-1:0] cursor_ypos,
  input  logic [2:0]            color,
  input  logic                  wr_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [2:0]            wr_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PAINT,
    CLEAR,
    FINISH
  } state_t;

  state_t state;
  state_t state_next;

  // Operation parameters frozen when leaving IDLE.
  logic                  mode_clear;
  logic [HPOS_WIDTH-1:0] cap_x;
  logic [VPOS_WIDTH-1:0] cap_y;
  logic [2:0]            cap_color;

  // Raster bounds and position. The left edge is kept to restart each row;
  // the top edge is only needed once, to seed the row base in SETUP.
  logic [HPOS_WIDTH-1:0] x0_r;
  logic [HPOS_WIDTH-1:0] x1_r;
  logic [VPOS_WIDTH-1:0] y1_r;
  logic [HPOS_WIDTH-1:0] cur_x;
  logic [VPOS_WIDTH-1:0] cur_y;
  logic [ADDR_WIDTH-1:0] row_base;

  // Bounds computed from the captured cursor during SETUP.
  int                    lo_x;
  int                    hi_x;
  int                    lo_y;
  int                    hi_y;
  logic                  setup_empty;
  logic [ADDR_WIDTH-1:0] setup_base;
  logic [ADDR_WIDTH-1:0] setup_addr;

  logic                  req_any;
  logic                  accept;
  logic                  last_col;
  logic                  last_pix;

  assign req_any  = paint_req | clear_req;
  assign accept   = wr_en & wr_ready;
  assign last_col = (cur_x == x1_r);
  assign last_pix = last_col && (cur_y == y1_r);

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  // Clamp the brush square to the screen using signed arithmetic so a cursor
  // near the origin never wraps; a cursor far off-screen yields lo > hi.
  always_comb begin
    lo_x = int'(cap_x) - BRUSH_SIZE;
    hi_x = int'(cap_x) + BRUSH_SIZE;
    lo_y = int'(cap_y) - BRUSH_SIZE;
    hi_y = int'(cap_y) + BRUSH_SIZE;
    if (lo_x < 0) lo_x = 0;
    if (lo_y < 0) lo_y = 0;
    if (hi_x > RESOLUTION_H - 1) hi_x = RESOLUTION_H - 1;
    if (hi_y > RESOLUTION_V - 1) hi_y = RESOLUTION_V - 1;
    if (mode_clear) begin
      lo_x = 0;
      hi_x = RESOLUTION_H - 1;
      lo_y = 0;
      hi_y = RESOLUTION_V - 1;
    end
    setup_empty = (lo_x > hi_x) || (lo_y > hi_y);
    setup_base  = ADDR_WIDTH'(lo_y * RESOLUTION_H);
    setup_addr  = setup_base + ADDR_WIDTH'(lo_x);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: clear has priority, requests only sampled in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_any) state_next = SETUP;
      end
      SETUP: begin
        if (setup_empty)     state_next = FINISH;
        else if (mode_clear) state_next = CLEAR;
        else                 state_next = PAINT;
      end
      PAINT, CLEAR: begin
        if (accept && last_pix) state_next = FINISH;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture request parameters when leaving IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_clear <= 1'b0;
      cap_x      <= '0;
      cap_y      <= '0;
      cap_color  <= '0;
    end else if (state == IDLE && req_any) begin
      mode_clear <= clear_req;
      cap_x      <= cursor_xpos;
      cap_y      <= cursor_ypos;
      cap_color  <= color;
    end
  end

  // Raster walker and write port: seed in SETUP, step on each accepted write,
  // moving to the next row via an incremental row base instead of a multiply.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_r     <= '0;
      x1_r     <= '0;
      y1_r     <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      row_base <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        SETUP: begin
          x0_r     <= HPOS_WIDTH'(lo_x);
          x1_r     <= HPOS_WIDTH'(hi_x);
          y1_r     <= VPOS_WIDTH'(hi_y);
          cur_x    <= HPOS_WIDTH'(lo_x);
          cur_y    <= VPOS_WIDTH'(lo_y);
          row_base <= setup_base;
          wr_addr  <= setup_addr;
          wr_data  <= mode_clear ? CLEAR_COLOR : cap_color;
          wr_en    <= !setup_empty;
        end
        PAINT, CLEAR: begin
          if (accept) begin
            if (last_pix) begin
              wr_en <= 1'b0;
            end else if (last_col) begin
              cur_x    <= x0_r;
              cur_y    <= cur_y + VPOS_WIDTH'(1);
              row_base <= row_base + ADDR_WIDTH'(RESOLUTION_H);
              wr_addr  <= row_base + ADDR_WIDTH'(RESOLUTION_H) + ADDR_WIDTH'(x0_r);
            end else begin
              cur_x   <= cur_x + HPOS_WIDTH'(1);
              wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_painter.sv
// Bench for fb_painter: a full-size instance for brush cases and a small-screen instance for full clears.
// Expected pixel streams come from a raster model built when each request is issued.
// A negedge monitor compares every accepted write, hold stability under stall and idle wr_en.
module tb_fb_painter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       paint_req;
  logic [1:0]       clear_req;
  logic [1:0]       wr_ready;
  logic [9:0]       cur_x;
  logic [9:0]       cur_y;
  logic [2:0]       col;
  logic [1:0]       wr_en_w;
  logic [1:0]       busy_w;
  logic [1:0]       done_w;
  logic [1:0][18:0] wr_addr_w;
  logic [1:0][2:0]  wr_data_w;

  fb_painter u_main (
    .clk(clk), .reset(rst[0]), .paint_req(paint_req[0]), .clear_req(clear_req[0]),
    .cursor_xpos(cur_x), .cursor_ypos(cur_y), .color(col), .wr_ready(wr_ready[0]),
    .wr_en(wr_en_w[0]), .wr_addr(wr_addr_w[0]), .wr_data(wr_data_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  fb_painter #(
    .RESOLUTION_H(16), .RESOLUTION_V(12), .BRUSH_SIZE(3), .CLEAR_COLOR(3'b101)
  ) u_small (
    .clk(clk), .reset(rst[1]), .paint_req(paint_req[1]), .clear_req(clear_req[1]),
    .cursor_xpos(cur_x), .cursor_ypos(cur_y), .color(col), .wr_ready(wr_ready[1]),
    .wr_en(wr_en_w[1]), .wr_addr(wr_addr_w[1]), .wr_data(wr_data_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  int total = 0;
  int bad   = 0;
  int acc_cnt[2];
  int done_cnt[2];
  int first_addr[2];
  int last_addr[2];
  int prev_addr[2];
  int prev_data[2];
  bit prev_stall[2];
  int q0[$];
  int q1[$];

  function automatic int ph(int k); return (k == 0) ? 640 : 16; endfunction
  function automatic int pv(int k); return (k == 0) ? 480 : 12; endfunction
  function automatic int pb(int k); return (k == 0) ? 20 : 3; endfunction
  function automatic int pc(int k); return (k == 0) ? 0 : 5; endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront(int k);
    if (qsize(k) == 0) return -1;
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qclear(int k);
    if (k == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected writes, each encoded as addr*8+data, in raster order.
  task automatic build(int k, bit clr, int cx, int cy, logic [2:0] c);
    int x0, x1, y0, y1, d;
    if (clr) begin
      x0 = 0; x1 = ph(k) - 1; y0 = 0; y1 = pv(k) - 1; d = pc(k);
    end else begin
      x0 = (cx - pb(k) < 0) ? 0 : cx - pb(k);
      y0 = (cy - pb(k) < 0) ? 0 : cy - pb(k);
      x1 = (cx + pb(k) > ph(k) - 1) ? ph(k) - 1 : cx + pb(k);
      y1 = (cy + pb(k) > pv(k) - 1) ? pv(k) - 1 : cy + pb(k);
      d  = int'(c);
    end
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        if (k == 0) q0.push_back((y * ph(k) + x) * 8 + d);
        else        q1.push_back((y * ph(k) + x) * 8 + d);
  endtask

  // Monitor: outputs sampled on the falling edge reflect what the next rising edge sees.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) begin
          qclear(k);
          prev_stall[k] = 1'b0;
        end else begin
          if (prev_stall[k]) begin
            check("hold_en", int'(wr_en_w[k]), 1);
            check("hold_addr", int'(wr_addr_w[k]), prev_addr[k]);
            check("hold_data", int'(wr_data_w[k]), prev_data[k]);
          end
          if (qsize(k) == 0) begin
            check("idle_wr_en", int'(wr_en_w[k]), 0);
          end else if (wr_en_w[k] && wr_ready[k]) begin
            check("pixel", int'(wr_addr_w[k]) * 8 + int'(wr_data_w[k]), qfront(k));
            qpop(k);
            if (acc_cnt[k] == 0) first_addr[k] = int'(wr_addr_w[k]);
            last_addr[k] = int'(wr_addr_w[k]);
            acc_cnt[k]++;
          end
          if (done_w[k]) done_cnt[k]++;
          prev_stall[k] = wr_en_w[k] && !wr_ready[k];
          prev_addr[k]  = int'(wr_addr_w[k]);
          prev_data[k]  = int'(wr_data_w[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(int k, bit clr, bit pnt, int cx, int cy, logic [2:0] c);
    cur_x = 10'(cx);
    cur_y = 10'(cy);
    col   = c;
    clear_req[k] = clr;
    paint_req[k] = pnt;
    acc_cnt[k]    = 0;
    first_addr[k] = -1;
    last_addr[k]  = -1;
    build(k, clr, cx, cy, c);
    tick();
    clear_req[k] = 1'b0;
    paint_req[k] = 1'b0;
  endtask

  task automatic run_op(int k, bit rnd, int budget);
    int d0;
    d0 = done_cnt[k];
    for (int i = 0; i < budget; i++) begin
      wr_ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (done_cnt[k] != d0) break;
    end
    check("op_done", done_cnt[k] - d0, 1);
    wr_ready[k] = 1'b1;
    repeat (3) tick();
    check("done_once", done_cnt[k] - d0, 1);
    check("busy_after", int'(busy_w[k]), 0);
    check("q_drained", qsize(k), 0);
  endtask

  task automatic check_op(int k, int n, int fa, int la);
    check("write_count", acc_cnt[k], n);
    check("first_addr", first_addr[k], fa);
    check("last_addr", last_addr[k], la);
  endtask

  initial begin
    rst = 2'b11; paint_req = 2'b00; clear_req = 2'b00; wr_ready = 2'b00;
    cur_x = '0; cur_y = '0; col = '0;
    for (int k = 0; k < 2; k++) begin
      acc_cnt[k] = 0; done_cnt[k] = 0; prev_stall[k] = 1'b0;
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      check("rst_wr_en", int'(wr_en_w[k]), 0);
      check("rst_wr_addr", int'(wr_addr_w[k]), 0);
      check("rst_wr_data", int'(wr_data_w[k]), 0);
      check("rst_busy", int'(busy_w[k]), 0);
      check("rst_done", int'(done_w[k]), 0);
    end
    tick();
    rst = 2'b00;
    wr_ready = 2'b11;
    tick();

    // Centred brush.
    start_op(0, 1'b0, 1'b1, 320, 240, 3'b011);
    check("model_n_centre", qsize(0), 1681);
    check("model_first_centre", qfront(0), 141100 * 8 + 3);
    check("busy_setup", int'(busy_w[0]), 1);
    run_op(0, 1'b0, 4000);
    check_op(0, 1681, 141100, 166740);

    // Brush clipped at the top-left corner.
    start_op(0, 1'b0, 1'b1, 5, 3, 3'b101);
    check("model_n_corner", qsize(0), 624);
    run_op(0, 1'b0, 2000);
    check_op(0, 624, 0, 23 * 640 + 25);

    // Bottom-right corner under random backpressure.
    start_op(0, 1'b0, 1'b1, 630, 470, 3'b110);
    check("model_n_stall", qsize(0), 900);
    run_op(0, 1'b1, 8000);
    check_op(0, 900, 288610, 307199);

    // Cursor fully off-screen: no writes, still one done.
    start_op(0, 1'b0, 1'b1, 700, 100, 3'b111);
    check("model_n_off", qsize(0), 0);
    run_op(0, 1'b0, 20);
    check("off_writes", acc_cnt[0], 0);

    // Inputs and requests change while busy; captured values must be used.
    start_op(0, 1'b0, 1'b1, 50, 60, 3'b001);
    cur_x = 10'd400; cur_y = 10'd300; col = 3'b100;
    repeat (40) tick();
    paint_req[0] = 1'b1;
    tick();
    paint_req[0] = 1'b0;
    clear_req[0] = 1'b1;
    tick();
    clear_req[0] = 1'b0;
    run_op(0, 1'b0, 4000);
    check_op(0, 1681, 25630, 51270);
    repeat (10) tick();
    check("no_queued_op", int'(busy_w[0]), 0);

    // Reset after the 100th accepted write.
    start_op(0, 1'b0, 1'b1, 100, 100, 3'b010);
    for (int i = 0; i < 500; i++) begin
      tick();
      if (acc_cnt[0] == 100) break;
    end
    check("reach_100", acc_cnt[0], 100);
    rst[0] = 1'b1;
    #1;
    check("abort_wr_en", int'(wr_en_w[0]), 0);
    check("abort_busy", int'(busy_w[0]), 0);
    check("abort_done", int'(done_w[0]), 0);
    check("abort_addr", int'(wr_addr_w[0]), 0);
    tick();
    tick();
    rst[0] = 1'b0;
    repeat (20) tick();
    check("abort_no_writes", acc_cnt[0], 100);
    check("abort_idle", int'(busy_w[0]), 0);

    // Small screen: clear and paint together, clear wins.
    start_op(1, 1'b1, 1'b1, 3, 3, 3'b111);
    check("model_n_clear", qsize(1), 192);
    check("model_first_clear", qfront(1), 5);
    run_op(1, 1'b0, 1000);
    check_op(1, 192, 0, 191);

    // Small screen: brush clipped at the right edge and top.
    start_op(1, 1'b0, 1'b1, 14, 1, 3'b010);
    check("model_n_small", qsize(1), 25);
    run_op(1, 1'b0, 200);
    check_op(1, 25, 11, 79);

    // Small screen: cursor beyond the right edge by more than the brush.
    start_op(1, 1'b0, 1'b1, 30, 5, 3'b001);
    run_op(1, 1'b0, 20);
    check("small_off_writes", acc_cnt[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
